// File: rtl/pipe_ctrl_pkg.sv
// Shared types and select encodings for the pipeline hazard/forwarding controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } ctrl_state_e;

  // EX operand select encodings
  localparam logic [2:0] FWD_RF  = 3'd0;
  localparam logic [2:0] FWD_WB  = 3'd1;
  localparam logic [2:0] FWD_MEM = 3'd2;

  // ID branch-comparator select encodings (MEM and WB swap codes here)
  localparam logic [1:0] ID_FWD_RF  = 2'd0;
  localparam logic [1:0] ID_FWD_MEM = 2'd1;
  localparam logic [1:0] ID_FWD_WB  = 2'd2;

endpackage

// File: rtl/fwd_sel.sv
// Priority forwarding comparator for one source register: a MEM-stage match
// wins over a WB-stage match, and register 0 never forwards.
module fwd_sel #(
  parameter int RW = 5
) (
  input  logic [RW-1:0] src,
  input  logic [RW-1:0] mem_wreg,
  input  logic          mem_regWrite,
  input  logic [RW-1:0] wb_wreg,
  input  logic          wb_regWrite,
  output logic          mem_hit,
  output logic          wb_hit
);

  // Resolve MEM-over-WB priority so at most one hit is ever raised
  always_comb begin
    mem_hit = 1'b0;
    wb_hit  = 1'b0;
    if (mem_regWrite && (mem_wreg != '0) && (mem_wreg == src)) begin
      mem_hit = 1'b1;
    end else if (wb_regWrite && (wb_wreg != '0) && (wb_wreg == src)) begin
      wb_hit = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: EX and ID
// forwarding selects, load-use / branch stalls, IF/ID flush on taken jumps,
// and a whole-pipeline freeze while the data memory is busy, with timeout.
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int RW       = 5,
  parameter int WAIT_MAX = 15,
  parameter int CW       = 4,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RW-1:0]     id_rs,
  input  logic [RW-1:0]     id_rt,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              id_take_jb,
  input  logic [RW-1:0]     ex_rs,
  input  logic [RW-1:0]     ex_rt,
  input  logic [RW-1:0]     ex_wreg,
  input  logic              ex_regWrite,
  input  logic              ex_memRead,
  input  logic [RW-1:0]     mem_wreg,
  input  logic              mem_regWrite,
  input  logic              mem_memRead,
  input  logic              mem_memWrite,
  input  logic [RW-1:0]     wb_wreg,
  input  logic              wb_regWrite,
  input  logic              dmem_ready,
  output logic [2:0]        forwardA,
  output logic [2:0]        forwardB,
  output logic [1:0]        id_fwdA,
  output logic [1:0]        id_fwdB,
  output logic              pcWrite,
  output logic              ifidWrite,
  output logic              stall_needed,
  output logic              ifidFlush,
  output logic              pipe_freeze,
  output logic              timeout_err,
  output logic [PERF_W-1:0] stall_cnt
);

  ctrl_state_e       state_q, state_d;
  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CW-1:0]     wait_cnt_inc;
  logic [PERF_W-1:0] stall_cnt_q;

  logic exa_mem, exa_wb, exb_mem, exb_wb;
  logic ida_mem, ida_wb, idb_mem, idb_wb;
  logic h_load_use, h_br_alu, h_br_load, hazard, mem_busy;

  // True when a producer's destination feeds a source of the ID instruction
  function automatic logic dest_hit(input logic [RW-1:0] dest,
                                    input logic [RW-1:0] rs,
                                    input logic [RW-1:0] rt,
                                    input logic          uses_rt);
    return (dest != '0) && ((dest == rs) || (uses_rt && (dest == rt)));
  endfunction

  fwd_sel #(.RW(RW)) u_fwd_exa (
    .src(ex_rs), .mem_wreg(mem_wreg), .mem_regWrite(mem_regWrite),
    .wb_wreg(wb_wreg), .wb_regWrite(wb_regWrite), .mem_hit(exa_mem), .wb_hit(exa_wb)
  );

  fwd_sel #(.RW(RW)) u_fwd_exb (
    .src(ex_rt), .mem_wreg(mem_wreg), .mem_regWrite(mem_regWrite),
    .wb_wreg(wb_wreg), .wb_regWrite(wb_regWrite), .mem_hit(exb_mem), .wb_hit(exb_wb)
  );

  fwd_sel #(.RW(RW)) u_fwd_ida (
    .src(id_rs), .mem_wreg(mem_wreg), .mem_regWrite(mem_regWrite),
    .wb_wreg(wb_wreg), .wb_regWrite(wb_regWrite), .mem_hit(ida_mem), .wb_hit(ida_wb)
  );

  fwd_sel #(.RW(RW)) u_fwd_idb (
    .src(id_rt), .mem_wreg(mem_wreg), .mem_regWrite(mem_regWrite),
    .wb_wreg(wb_wreg), .wb_regWrite(wb_regWrite), .mem_hit(idb_mem), .wb_hit(idb_wb)
  );

  // Map comparator hits onto the EX and ID select encodings
  always_comb begin
    forwardA = exa_mem ? FWD_MEM : (exa_wb ? FWD_WB : FWD_RF);
    forwardB = exb_mem ? FWD_MEM : (exb_wb ? FWD_WB : FWD_RF);
    id_fwdA  = ida_mem ? ID_FWD_MEM : (ida_wb ? ID_FWD_WB : ID_FWD_RF);
    id_fwdB  = idb_mem ? ID_FWD_MEM : (idb_wb ? ID_FWD_WB : ID_FWD_RF);
  end

  // Detect data hazards that need a bubble and a busy data memory
  always_comb begin
    h_load_use = ex_memRead && ex_regWrite &&
                 dest_hit(ex_wreg, id_rs, id_rt, id_uses_rt);
    h_br_alu   = id_is_branch && ex_regWrite && !ex_memRead &&
                 dest_hit(ex_wreg, id_rs, id_rt, id_uses_rt);
    h_br_load  = id_is_branch && mem_memRead &&
                 dest_hit(mem_wreg, id_rs, id_rt, id_uses_rt);
    hazard     = h_load_use || h_br_alu || h_br_load;
    mem_busy   = (mem_memRead || mem_memWrite) && !dmem_ready;
  end

  assign wait_cnt_inc = wait_cnt_q + 1'b1;

  // Next state and control outputs: freeze beats stall beats flush
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    pcWrite      = 1'b1;
    ifidWrite    = 1'b1;
    stall_needed = 1'b0;
    ifidFlush    = 1'b0;
    pipe_freeze  = 1'b0;
    case (state_q)
      RUN, MEM_WAIT: begin
        if ((state_q == RUN && mem_busy) || (state_q == MEM_WAIT && !dmem_ready)) begin
          pipe_freeze = 1'b1;
          pcWrite     = 1'b0;
          ifidWrite   = 1'b0;
          wait_cnt_d  = wait_cnt_inc;
          state_d     = (wait_cnt_inc == CW'(WAIT_MAX)) ? TIMEOUT : MEM_WAIT;
        end else begin
          state_d = RUN;
          if (hazard) begin
            stall_needed = 1'b1;
            pcWrite      = 1'b0;
            ifidWrite    = 1'b0;
          end else if (id_take_jb) begin
            ifidFlush = 1'b1;
          end
        end
      end
      TIMEOUT: begin
        pipe_freeze = 1'b1;
        pcWrite     = 1'b0;
        ifidWrite   = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  // State, wait counter and saturating stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if ((stall_needed || pipe_freeze) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign timeout_err = (state_q == TIMEOUT);
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expectations.
// A second, narrow instance (3-bit stall counter, WAIT_MAX=2) covers
// counter saturation and a short timeout on the same stimulus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
  logic       id_uses_rt, id_is_branch, id_take_jb;
  logic       ex_regWrite, ex_memRead;
  logic       mem_regWrite, mem_memRead, mem_memWrite, wb_regWrite, dmem_ready;

  logic [2:0]  forwardA, forwardB;
  logic [1:0]  id_fwdA, id_fwdB;
  logic        pcWrite, ifidWrite, stall_needed, ifidFlush, pipe_freeze, timeout_err;
  logic [15:0] stall_cnt;

  logic [2:0]  s_forwardA, s_forwardB;
  logic [1:0]  s_id_fwdA, s_id_fwdB;
  logic        s_pcWrite, s_ifidWrite, s_stall_needed, s_ifidFlush, s_pipe_freeze, s_timeout_err;
  logic [2:0]  s_stall_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RW(5), .WAIT_MAX(15), .CW(4), .PERF_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_take_jb(id_take_jb),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .mem_wreg(mem_wreg), .mem_regWrite(mem_regWrite),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
    .wb_wreg(wb_wreg), .wb_regWrite(wb_regWrite), .dmem_ready(dmem_ready),
    .forwardA(forwardA), .forwardB(forwardB), .id_fwdA(id_fwdA), .id_fwdB(id_fwdB),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .stall_needed(stall_needed),
    .ifidFlush(ifidFlush), .pipe_freeze(pipe_freeze), .timeout_err(timeout_err),
    .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.RW(5), .WAIT_MAX(2), .CW(4), .PERF_W(3)) u_sat (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_take_jb(id_take_jb),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .mem_wreg(mem_wreg), .mem_regWrite(mem_regWrite),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
    .wb_wreg(wb_wreg), .wb_regWrite(wb_regWrite), .dmem_ready(dmem_ready),
    .forwardA(s_forwardA), .forwardB(s_forwardB), .id_fwdA(s_id_fwdA), .id_fwdB(s_id_fwdB),
    .pcWrite(s_pcWrite), .ifidWrite(s_ifidWrite), .stall_needed(s_stall_needed),
    .ifidFlush(s_ifidFlush), .pipe_freeze(s_pipe_freeze), .timeout_err(s_timeout_err),
    .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_is_branch = 1'b0; id_take_jb = 1'b0;
    ex_rs = '0; ex_rt = '0; ex_wreg = '0; ex_regWrite = 1'b0; ex_memRead = 1'b0;
    mem_wreg = '0; mem_regWrite = 1'b0; mem_memRead = 1'b0; mem_memWrite = 1'b0;
    wb_wreg = '0; wb_regWrite = 1'b0; dmem_ready = 1'b1;
  endtask

  // lw r5 sitting in EX
  task automatic load_in_ex();
    ex_wreg = 5'd5; ex_regWrite = 1'b1; ex_memRead = 1'b1;
  endtask

  // One clock; counts an expected stall/freeze cycle when asked
  task automatic cyc(input bit counted);
    @(posedge clk);
    if (counted) exp_cnt++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #1;
    chk("rst_freeze", pipe_freeze, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_pcWrite", pcWrite, 1);
    chk("rst_ifidWrite", ifidWrite, 1);
    @(negedge clk);
    rst = 1'b1;

    // EX forwarding: MEM beats WB, WB next, r0 never forwards
    idle(); ex_rs = 5'd3; mem_wreg = 5'd3; mem_regWrite = 1'b1; wb_wreg = 5'd3; wb_regWrite = 1'b1;
    #1 chk("fwdA_mem", forwardA, 2);
    mem_regWrite = 1'b0;
    #1 chk("fwdA_wb", forwardA, 1);
    idle(); ex_rs = 5'd0; mem_wreg = 5'd0; mem_regWrite = 1'b1;
    #1 chk("fwdA_r0", forwardA, 0);
    idle(); ex_rt = 5'd4; wb_wreg = 5'd4; wb_regWrite = 1'b1;
    #1 chk("fwdB_wb", forwardB, 1);
    idle(); id_rs = 5'd7; mem_wreg = 5'd7; mem_regWrite = 1'b1;
    #1 chk("idfwdA_mem", id_fwdA, 1);
    mem_regWrite = 1'b0; wb_wreg = 5'd7; wb_regWrite = 1'b1;
    #1 chk("idfwdA_wb", id_fwdA, 2);
    cyc(0);

    // Load-use: one stall cycle, then WB forwarding
    idle(); load_in_ex(); id_rs = 5'd5;
    #1 chk("lu_stall", stall_needed, 1);
    chk("lu_pcWrite", pcWrite, 0);
    chk("lu_ifidWrite", ifidWrite, 0);
    cyc(1);
    chk("lu_cnt", stall_cnt, 1);
    idle(); mem_wreg = 5'd5; mem_regWrite = 1'b1; mem_memRead = 1'b1; id_rs = 5'd5;
    #1 chk("lu_stall_gone", stall_needed, 0);
    chk("lu_pc_resume", pcWrite, 1);
    cyc(0);
    idle(); wb_wreg = 5'd5; wb_regWrite = 1'b1; ex_rs = 5'd5;
    #1 chk("lu_fwdA_wb", forwardA, 1);
    cyc(0);
    idle(); load_in_ex(); id_rs = 5'd7; id_rt = 5'd5; id_uses_rt = 1'b0;
    #1 chk("lu_rt_unused", stall_needed, 0);
    id_uses_rt = 1'b1;
    #1 chk("lu_rt_used", stall_needed, 1);
    cyc(1);

    // Branch on fresh load: H1 then H3, then forward + flush
    idle(); load_in_ex(); id_rs = 5'd5; id_rt = 5'd6; id_uses_rt = 1'b1; id_is_branch = 1'b1;
    #1 chk("br_h1", stall_needed, 1);
    cyc(1);
    idle(); mem_wreg = 5'd5; mem_regWrite = 1'b1; mem_memRead = 1'b1;
    id_rs = 5'd5; id_rt = 5'd6; id_uses_rt = 1'b1; id_is_branch = 1'b1;
    #1 chk("br_h3", stall_needed, 1);
    chk("br_h3_pc", pcWrite, 0);
    cyc(1);
    idle(); wb_wreg = 5'd5; wb_regWrite = 1'b1;
    id_rs = 5'd5; id_rt = 5'd6; id_uses_rt = 1'b1; id_is_branch = 1'b1; id_take_jb = 1'b1;
    #1 chk("br_go_stall", stall_needed, 0);
    chk("br_idfwdA", id_fwdA, 2);
    chk("br_flush", ifidFlush, 1);
    chk("br_pcWrite", pcWrite, 1);
    cyc(0);
    idle(); ex_wreg = 5'd6; ex_regWrite = 1'b1;
    id_rs = 5'd5; id_rt = 5'd6; id_uses_rt = 1'b1; id_is_branch = 1'b1; id_take_jb = 1'b1;
    #1 chk("br_h2", stall_needed, 1);
    chk("br_h2_noflush", ifidFlush, 0);
    cyc(1);
    idle(); mem_wreg = 5'd6; mem_regWrite = 1'b1;
    id_rs = 5'd5; id_rt = 5'd6; id_uses_rt = 1'b1; id_is_branch = 1'b1;
    #1 chk("br_h2_done", stall_needed, 0);
    chk("br_idfwdB", id_fwdB, 1);
    cyc(0);
    chk("br_cnt", stall_cnt, exp_cnt);

    // Store with memory busy for 3 cycles
    idle(); mem_memWrite = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("sw_freeze", pipe_freeze, 1);
      chk("sw_pcWrite", pcWrite, 0);
      chk("sw_nostall", stall_needed, 0);
      cyc(1);
    end
    dmem_ready = 1'b1;
    #1 chk("sw_release", pipe_freeze, 0);
    chk("sw_pc_resume", pcWrite, 1);
    cyc(0);
    chk("sw_cnt", stall_cnt, exp_cnt);
    idle(); mem_memRead = 1'b1;
    #1 chk("ready_same_cycle", pipe_freeze, 0);
    cyc(0);

    // Freeze coincident with load-use and taken jump
    idle(); mem_wreg = 5'd9; mem_memRead = 1'b1; dmem_ready = 1'b0;
    load_in_ex(); id_rs = 5'd5; id_take_jb = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 chk("co_freeze", pipe_freeze, 1);
      chk("co_nostall", stall_needed, 0);
      chk("co_noflush", ifidFlush, 0);
      cyc(1);
    end
    dmem_ready = 1'b1;
    #1 chk("co_unfreeze", pipe_freeze, 0);
    chk("co_stall_after", stall_needed, 1);
    chk("co_noflush_after", ifidFlush, 0);
    cyc(1);
    idle(); id_take_jb = 1'b1;
    #1 chk("co_flush_after", ifidFlush, 1);
    cyc(0);
    chk("co_cnt", stall_cnt, exp_cnt);

    // Timeout: memory never answers
    rst = 1'b0; idle();
    #1 chk("rst2_cnt", stall_cnt, 0);
    chk("rst2_sat_timeout", s_timeout_err, 0);
    @(negedge clk);
    rst = 1'b1; exp_cnt = 0;
    mem_memRead = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (i == 1) chk("sat_to_pending", s_timeout_err, 0);
      if (i == 2) chk("sat_to_set", s_timeout_err, 1);
      if (i == 14) chk("to_pending", timeout_err, 0);
      cyc(1);
    end
    #1 chk("to_set", timeout_err, 1);
    chk("to_freeze", pipe_freeze, 1);
    dmem_ready = 1'b1;
    #1 chk("to_hold", pipe_freeze, 1);
    chk("to_pcWrite", pcWrite, 0);
    cyc(1);
    chk("to_cnt", stall_cnt, exp_cnt);
    chk("sat_cnt", s_stall_cnt, 7);
    idle(); rst = 1'b0;
    #1 chk("to_rst_err", timeout_err, 0);
    chk("to_rst_freeze", pipe_freeze, 0);
    @(negedge clk);
    rst = 1'b1;

    // Reset while in MEM_WAIT returns to RUN
    mem_memWrite = 1'b1; dmem_ready = 1'b0;
    cyc(0);
    mem_memWrite = 1'b0;
    #1 chk("mw_frozen", pipe_freeze, 1);
    rst = 1'b0;
    #1 chk("mw_rst_freeze", pipe_freeze, 0);
    chk("mw_rst_pc", pcWrite, 1);
    @(negedge clk);
    rst = 1'b1;
    cyc(0);
    chk("mw_run", pipe_freeze, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
